// File: rtl/sdram_read_sequencer.sv
// Splits one large SDRAM read into chunked go/done jobs for the Qsys read master and
// drains the master's show-ahead FIFO onto a valid/ready stream, counting and summing words.
module sdram_read_sequencer #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 32,
   parameter int CHUNK_WORDS    = 8,
   parameter int BYTES_PER_WORD = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] total_words,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W-1:0] word_count,
   output logic [15:0]       checksum,
   output logic              ctl_fixed_location,
   output logic [ADDR_W-1:0] ctl_read_base,
   output logic [ADDR_W-1:0] ctl_read_length,
   output logic              ctl_go,
   input  logic              ctl_done,
   output logic              usr_read_buffer,
   input  logic [DATA_W-1:0] usr_buffer_output_data,
   input  logic              usr_data_available,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_ARM    = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] CHUNK_LIM = ADDR_W'(CHUNK_WORDS);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BYTES_PER_WORD);
   localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;
   logic [ADDR_W-1:0] chunk_len_q, chunk_len_d;
   logic [ADDR_W-1:0] popped_q, popped_d;
   logic [ADDR_W-1:0] word_count_q, word_count_d;
   logic [ADDR_W-1:0] ctl_read_base_q, ctl_read_base_d;
   logic [ADDR_W-1:0] ctl_read_length_q, ctl_read_length_d;
   logic [15:0]       checksum_q, checksum_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              ctl_go_q, ctl_go_d;

   logic              streaming_s;
   logic              pop_s;
   logic              chunk_done_s;
   logic [ADDR_W-1:0] launch_len_s;
   logic [ADDR_W-1:0] remaining_after_s;

   // ARM exists only to skip the stale ctl_done the master shows while idle
   assign streaming_s       = (state_q == S_ARM) || (state_q == S_WAIT);
   assign out_data          = usr_buffer_output_data;
   assign out_valid         = streaming_s & usr_data_available;
   assign usr_read_buffer   = out_valid & out_ready;
   assign pop_s             = usr_read_buffer;
   assign chunk_done_s      = (state_q == S_WAIT) && ctl_done && (popped_q == chunk_len_q);
   assign launch_len_s      = (remaining_q < CHUNK_LIM) ? remaining_q : CHUNK_LIM;
   assign remaining_after_s = remaining_q - chunk_len_q;

   assign busy               = busy_q;
   assign done               = done_q;
   assign aborted            = aborted_q;
   assign word_count         = word_count_q;
   assign checksum           = checksum_q;
   assign ctl_fixed_location = 1'b0;
   assign ctl_read_base      = ctl_read_base_q;
   assign ctl_read_length    = ctl_read_length_q;
   assign ctl_go             = ctl_go_q;

   // State and datapath registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q           <= S_IDLE;
         cur_addr_q        <= ZERO_A;
         remaining_q       <= ZERO_A;
         chunk_len_q       <= ZERO_A;
         popped_q          <= ZERO_A;
         word_count_q      <= ZERO_A;
         ctl_read_base_q   <= ZERO_A;
         ctl_read_length_q <= ZERO_A;
         checksum_q        <= 16'h0000;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         aborted_q         <= 1'b0;
         ctl_go_q          <= 1'b0;
      end else begin
         state_q           <= state_d;
         cur_addr_q        <= cur_addr_d;
         remaining_q       <= remaining_d;
         chunk_len_q       <= chunk_len_d;
         popped_q          <= popped_d;
         word_count_q      <= word_count_d;
         ctl_read_base_q   <= ctl_read_base_d;
         ctl_read_length_q <= ctl_read_length_d;
         checksum_q        <= checksum_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         aborted_q         <= aborted_d;
         ctl_go_q          <= ctl_go_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (total_words == ZERO_A) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_LAUNCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: state_d = S_ARM;
         S_ARM:    state_d = S_WAIT;
         S_WAIT: begin
            if (chunk_done_s) begin
               if ((remaining_after_s == ZERO_A) || abort) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_LAUNCH;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Registered outputs and job bookkeeping
   always_comb begin
      cur_addr_d        = cur_addr_q;
      remaining_d       = remaining_q;
      chunk_len_d       = chunk_len_q;
      popped_d          = popped_q;
      word_count_d      = word_count_q;
      ctl_read_base_d   = ctl_read_base_q;
      ctl_read_length_d = ctl_read_length_q;
      checksum_d        = checksum_q;
      busy_d            = busy_q;
      aborted_d         = aborted_q;
      done_d            = 1'b0;
      ctl_go_d          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_addr_d   = base_addr;
               remaining_d  = total_words;
               word_count_d = ZERO_A;
               checksum_d   = 16'h0000;
               aborted_d    = 1'b0;
               busy_d       = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_LAUNCH: begin
            chunk_len_d       = launch_len_s;
            ctl_read_base_d   = cur_addr_q;
            ctl_read_length_d = launch_len_s * STRIDE;
            ctl_go_d          = 1'b1;
            popped_d          = ZERO_A;
         end
         S_ARM, S_WAIT: begin
            if (pop_s) begin
               popped_d     = popped_q + 32'(1);
               word_count_d = word_count_q + 32'(1);
               checksum_d   = checksum_q + 16'(usr_buffer_output_data);
            end else begin
               popped_d = popped_q;
            end
            // Abort is only honoured at a chunk boundary, never mid-chunk
            if (chunk_done_s) begin
               cur_addr_d  = cur_addr_q + chunk_len_q * STRIDE;
               remaining_d = remaining_after_s;
               aborted_d   = abort && (remaining_after_s != ZERO_A);
            end else begin
               remaining_d = remaining_q;
            end
         end
         S_FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Directed bench for sdram_read_sequencer: a bench-side read master fills a FIFO on each go,
// and a transaction-level model of chunks, stream words and totals is checked every cycle.
module tb_sdram_read_sequencer;

   localparam int DW  = 16;
   localparam int AW  = 32;
   localparam int CW  = 8;
   localparam int BPW = 2;

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = 32'h0;
   logic [AW-1:0] total_words = 32'h0;
   logic          busy, done, aborted;
   logic [AW-1:0] word_count;
   logic [15:0]   checksum;
   logic          ctl_fixed_location;
   logic [AW-1:0] ctl_read_base, ctl_read_length;
   logic          ctl_go;
   logic          ctl_done = 1'b1;
   logic          usr_read_buffer;
   logic [DW-1:0] usr_buffer_output_data = 16'h0;
   logic          usr_data_available = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;

   sdram_read_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CHUNK_WORDS(CW), .BYTES_PER_WORD(BPW)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .total_words(total_words),
      .busy(busy), .done(done), .aborted(aborted),
      .word_count(word_count), .checksum(checksum),
      .ctl_fixed_location(ctl_fixed_location), .ctl_read_base(ctl_read_base),
      .ctl_read_length(ctl_read_length), .ctl_go(ctl_go), .ctl_done(ctl_done),
      .usr_read_buffer(usr_read_buffer), .usr_buffer_output_data(usr_buffer_output_data),
      .usr_data_available(usr_data_available),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // bench-side read master
   logic [15:0] fifo[$];
   bit          mst_idle = 1'b1;
   int          done_after = 0;
   int          ready_mode = 1;

   // transaction-level model of the job
   bit            job_active = 1'b0;
   logic [AW-1:0] job_base = 32'h0;
   logic [AW-1:0] chunk_base[$];
   logic [AW-1:0] chunk_len[$];
   int            go_idx = 0;
   logic [AW-1:0] cur_base = 32'h0;
   logic [AW-1:0] cur_len = 32'h0;
   int            cur_words = 0;
   int            pops_in_chunk = 0;
   int            issued_words = 0;
   logic [AW-1:0] exp_wc = 32'h0;
   logic [15:0]   exp_cs = 16'h0;
   bit            abort_seen = 1'b0;
   int            gos_in_job = 0;
   logic [AW-1:0] go_base_log[$];
   logic [AW-1:0] go_len_log[$];
   int            start_cyc = 0;
   bit            done_seen = 1'b0;
   int            res_done_cyc = 0;
   logic [AW-1:0] res_wc = 32'h0;
   logic [15:0]   res_cs = 16'h0;
   logic          res_ab = 1'b0;
   int            res_gos = 0;

   function automatic logic [15:0] word_at(input logic [AW-1:0] a);
      return a[15:0] + 16'h1000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_and_advance();
      logic [15:0] w;
      logic [15:0] s;
      bit          exp_ab;
      if (reset) begin
         fifo.delete();
         mst_idle = 1'b1;
         job_active = 1'b0;
         chunk_base.delete();
         chunk_len.delete();
         go_idx = 0; cur_base = 32'h0; cur_len = 32'h0; cur_words = 0;
         pops_in_chunk = 0; issued_words = 0; exp_wc = 32'h0; exp_cs = 16'h0;
         abort_seen = 1'b0; gos_in_job = 0;
      end else begin
         if (!job_active || !usr_data_available) chk("valid_without_data", out_valid, 1'b0);
         if (!out_ready) chk("pop_without_ready", usr_read_buffer, 1'b0);
         chk("word_count", word_count, exp_wc);
         chk("checksum", checksum, exp_cs);
         chk("fixed_location", ctl_fixed_location, 1'b0);
         if (ctl_go) begin
            gos_in_job++;
            go_base_log.push_back(ctl_read_base);
            go_len_log.push_back(ctl_read_length);
            if (!job_active || go_idx >= chunk_base.size()) begin
               chk("go_unexpected", ctl_go, 1'b0);
            end else begin
               if (go_idx > 0) chk("go_before_drain", pops_in_chunk, cur_words);
               cur_base = chunk_base[go_idx];
               cur_len = chunk_len[go_idx];
               cur_words = int'(cur_len) / BPW;
               go_idx++;
               pops_in_chunk = 0;
               issued_words += cur_words;
            end
         end
         chk("read_base", ctl_read_base, cur_base);
         chk("read_length", ctl_read_length, cur_len);
         w = word_at(cur_base + 32'(BPW * pops_in_chunk));
         if (usr_read_buffer) begin
            chk("pop_data", out_data, w);
            n_cmp++;
            assert (pops_in_chunk < cur_words)
            else begin
               n_fail++;
               $display("FAIL pop_overrun: pop %0d in a chunk of %0d words", pops_in_chunk + 1, cur_words);
            end
         end
         if (done) begin
            chk("busy_at_done", busy, 1'b0);
            if (!job_active) begin
               chk("done_spurious", done, 1'b0);
            end else begin
               chk("done_drained", pops_in_chunk, cur_words);
               chk("done_word_count", word_count, issued_words);
               exp_ab = abort_seen && (go_idx < chunk_base.size());
               chk("done_aborted", aborted, exp_ab);
               if (!exp_ab) chk("done_all_chunks", go_idx, chunk_base.size());
               s = 16'h0;
               for (int i = 0; i < issued_words; i++) s += word_at(job_base + 32'(BPW * i));
               chk("done_checksum", checksum, s);
               done_seen = 1'b1;
               res_done_cyc = cyc;
               res_wc = word_count;
               res_cs = checksum;
               res_ab = aborted;
               res_gos = gos_in_job;
            end
         end else if (job_active) begin
            chk("busy_in_job", busy, 1'b1);
         end else begin
            chk("busy_idle", busy, 1'b0);
         end

         // effects of the coming clock edge
         if (usr_read_buffer) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            exp_wc = exp_wc + 32'd1;
            exp_cs = exp_cs + w;
            pops_in_chunk++;
         end
         if (done) job_active = 1'b0;
         if (abort && job_active) abort_seen = 1'b1;
         if (start && !job_active) begin
            logic [AW-1:0] a;
            logic [AW-1:0] rem;
            logic [AW-1:0] n;
            chunk_base.delete();
            chunk_len.delete();
            a = base_addr;
            rem = total_words;
            while (rem != 32'h0) begin
               n = (rem < 32'(CW)) ? rem : 32'(CW);
               chunk_base.push_back(a);
               chunk_len.push_back(n * 32'(BPW));
               a = a + n * 32'(BPW);
               rem = rem - n;
            end
            job_active = 1'b1; job_base = base_addr;
            exp_wc = 32'h0; exp_cs = 16'h0;
            go_idx = 0; cur_words = 0; pops_in_chunk = 0; issued_words = 0;
            abort_seen = abort; gos_in_job = 0;
            go_base_log.delete(); go_len_log.delete();
            start_cyc = cyc; done_seen = 1'b0;
         end
         if (ctl_go) begin
            for (int i = 0; i < int'(ctl_read_length) / BPW; i++)
               fifo.push_back(word_at(ctl_read_base + 32'(BPW * i)));
            mst_idle = 1'b0;
         end else if (!mst_idle && pops_in_chunk >= done_after) begin
            mst_idle = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge CLOCK_50);
      usr_data_available = (fifo.size() > 0);
      usr_buffer_output_data = (fifo.size() > 0) ? fifo[0] : 16'h0;
      ctl_done = mst_idle;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = cyc[0];
      endcase
      #1;
      check_and_advance();
      cyc++;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done_seen && n < budget) begin
         cycle();
         n++;
      end
      chk("job_finished_in_budget", done_seen, 1'b1);
   endtask

   task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] t, input int budget);
      base_addr = b;
      total_words = t;
      start = 1'b1;
      cycle();
      start = 1'b0;
      wait_done(budget);
   endtask

   initial begin
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_aborted", aborted, 1'b0);
      chk("rst_word_count", word_count, 32'h0);
      chk("rst_checksum", checksum, 16'h0);
      chk("rst_go", ctl_go, 1'b0);
      chk("rst_base", ctl_read_base, 32'h0);
      chk("rst_length", ctl_read_length, 32'h0);

      // three chunks, 20 words, checksum wraps past 16 bits
      ready_mode = 1;
      run_job(32'h100, 32'd20, 300);
      chk("s1_gos", res_gos, 3);
      if (go_base_log.size() == 3) begin
         chk("s1_go0_base", go_base_log[0], 32'h100);
         chk("s1_go0_len", go_len_log[0], 32'd16);
         chk("s1_go1_base", go_base_log[1], 32'h110);
         chk("s1_go1_len", go_len_log[1], 32'd16);
         chk("s1_go2_base", go_base_log[2], 32'h120);
         chk("s1_go2_len", go_len_log[2], 32'd8);
      end
      chk("s1_word_count", res_wc, 32'd20);
      chk("s1_checksum", res_cs, 16'h557C);
      chk("s1_aborted", res_ab, 1'b0);
      cycle();
      chk("s1_done_single", done, 1'b0);
      chk("s1_busy_after", busy, 1'b0);

      // empty job: done in the third cycle counting the start cycle
      run_job(32'h200, 32'd0, 10);
      chk("s2_done_latency", res_done_cyc - start_cyc, 2);
      chk("s2_gos", res_gos, 0);
      chk("s2_aborted", res_ab, 1'b0);

      // stalled drain with early ctl_done
      ready_mode = 2;
      done_after = 2;
      run_job(32'h2000, 32'd8, 200);
      chk("s3_gos", res_gos, 1);
      chk("s3_word_count", res_wc, 32'd8);
      done_after = 0;
      ready_mode = 1;

      // abort during the first of three chunks
      base_addr = 32'h3000;
      total_words = 32'd24;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 20 && gos_in_job == 0; i++) cycle();
      abort = 1'b1;
      wait_done(200);
      abort = 1'b0;
      chk("s4_aborted", res_ab, 1'b1);
      chk("s4_word_count", res_wc, 32'd8);
      chk("s4_gos", res_gos, 1);

      // start while busy is ignored
      base_addr = 32'h4000;
      total_words = 32'd10;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      base_addr = 32'h5000;
      total_words = 32'd3;
      start = 1'b1;
      cycle();
      start = 1'b0;
      wait_done(300);
      chk("s5_gos", res_gos, 2);
      chk("s5_word_count", res_wc, 32'd10);
      if (go_base_log.size() == 2) begin
         chk("s5_go1_base", go_base_log[1], 32'h4010);
         chk("s5_go1_len", go_len_log[1], 32'd4);
      end

      // reset mid-chunk after three pops, then a clean job
      base_addr = 32'h6000;
      total_words = 32'd8;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 30 && exp_wc < 32'd3; i++) cycle();
      chk("s6_popped_three", word_count, 32'd3);
      reset = 1'b1;
      ready_mode = 0;
      cycle();
      reset = 1'b0;
      cycle();
      chk("s6_busy", busy, 1'b0);
      chk("s6_go", ctl_go, 1'b0);
      chk("s6_word_count", word_count, 32'h0);
      chk("s6_checksum", checksum, 16'h0);
      chk("s6_valid", out_valid, 1'b0);
      ready_mode = 1;
      run_job(32'h7000, 32'd5, 100);
      chk("s6_fresh_word_count", res_wc, 32'd5);
      chk("s6_fresh_checksum", res_cs, 16'h8014);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
